// File: rtl/aes_enc_iter.sv
// Iterative AES encryptor: one forward round per clock, using the expanded key and S-box supplied from outside.
// Optional macro AES_ENC_B2B_EN: the next block loads in the same cycle as the output handshake.
`timescale 1ns/1ps
module aes_enc_iter #(
  parameter int NB = 4,
  parameter int NR = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [31:0]  KExp [NB*(NR+1)],
  input  logic [7:0]   SBox [256],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam int CW  = $clog2(NR + 1);
  localparam int KW  = NB * (NR + 1);
  localparam int KIW = $clog2(KW);
  localparam logic [CW-1:0] LAST = CW'(NR);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t        r_fsm, w_fsm_nxt;
  logic [127:0]  r_state, r_out;
  logic [CW-1:0] r_cnt;
  logic          w_load, w_last;
  logic [127:0]  w_rk0, w_rkey, w_sb, w_sr, w_mc, w_round;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round key for the load (round 0) and for the round currently being applied
  always_comb begin
    w_rk0  = '0;
    w_rkey = '0;
    for (int c = 0; c < NB; c++) begin
      w_rk0[127-32*c -: 32]  = KExp[KIW'(c)];
      w_rkey[127-32*c -: 32] = KExp[KIW'(NB * int'(r_cnt) + c)];
    end
  end

  always_comb begin
    w_sb = '0;
    for (int k = 0; k < 16; k++)
      w_sb[127-8*k -: 8] = SBox[r_state[127-8*k -: 8]];
  end

  // Row r of column c takes the byte from column (c+r) mod 4
  always_comb begin
    w_sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
  end

  always_comb begin
    w_mc = '0;
    for (int c = 0; c < 4; c++)
      w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
  end

  assign w_last  = (r_cnt == LAST);
  assign w_round = (w_last ? w_sr : w_mc) ^ w_rkey;

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load    = 1'b1;
          w_fsm_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        if (w_last) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
`ifdef AES_ENC_B2B_EN
        in_ready = out_ready;
        if (out_ready) begin
          w_load    = in_valid;
          w_fsm_nxt = in_valid ? S_ROUND : S_IDLE;
        end
`else
        if (out_ready) w_fsm_nxt = S_IDLE;
`endif
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  // The final round lands in the output register so the state register is free for the next load
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else if (w_load) begin
      r_state <= in_data ^ w_rk0;
      r_cnt   <= CW'(1);
    end else if (r_fsm == S_ROUND) begin
      if (w_last) begin
        r_out <= w_round;
      end else begin
        r_state <= w_round;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  assign out_data = r_out;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: FIPS-197 vectors on an AES-128 and an AES-256 instance, plus control scenarios.
`timescale 1ns/1ps
module tb_aes_enc_iter;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   sbox [256];
  logic [31:0]  kexp_a [44];
  logic [31:0]  kexp_b [60];
  logic [31:0]  ek [60];
  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [127:0] in_data_a, out_data_a;
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [127:0] in_data_b, out_data_b;
  int           checks = 0;
  int           errors = 0;

  aes_enc_iter #(.NB(4), .NR(10)) u_a (
    .clock(clock), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .KExp(kexp_a), .SBox(sbox), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a));

  aes_enc_iter #(.NB(4), .NR(14)) u_b (
    .clock(clock), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .KExp(kexp_b), .SBox(sbox), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b));

  always #5 clock = ~clock;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from the field inverse followed by the affine transform
  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input int nk, input int nr, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < nk; i++) ek[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = ek[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        rc = 8'h01;
        for (int j = 1; j < i/nk; j++) rc = xt(rc);
        t = t ^ {rc, 24'h000000};
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      ek[i] = ek[i-nk] ^ t;
    end
  endtask

  task automatic load_key_a(input logic [127:0] key);
    expand(4, 10, {key, 128'h0});
    for (int j = 0; j < 44; j++) kexp_a[j] = ek[j];
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic accept_a(input logic [127:0] pt);
    in_data_a  = pt;
    in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic wait_out_a(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid_a && n < 40);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_in_ready_a got %b want 1", in_ready_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_out_valid_a got %b want 0", out_valid_a); end
    checks++; if (out_data_a !== 128'h0) begin errors++; $display("FAIL rst_out_data_a got %h want 0", out_data_a); end
    checks++; if (in_ready_b !== 1'b1) begin errors++; $display("FAIL rst_in_ready_b got %b want 1", in_ready_b); end
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL rst_out_valid_b got %b want 0", out_valid_b); end
    checks++; if (out_data_b !== 128'h0) begin errors++; $display("FAIL rst_out_data_b got %h want 0", out_data_b); end
    reset = 1'b0;
  endtask

  task automatic test_aes128(input string name, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct);
    int n;
    load_key_a(key);
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL %s_idle_ready got %b want 1", name, in_ready_a); end
    accept_a(pt);
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL %s_busy_ready got %b want 0", name, in_ready_a); end
    wait_out_a(n);
    checks++; if (n != 10) begin errors++; $display("FAIL %s_latency got %0d want 10", name, n); end
    checks++; if (out_data_a !== ct) begin errors++; $display("FAIL %s_data got %h want %h", name, out_data_a, ct); end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++; $display("FAIL %s_handshake got valid=%b ready=%b want 0/1", name, out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_aes256;
    int n;
    expand(8, 14, KEY3);
    for (int j = 0; j < 60; j++) kexp_b[j] = ek[j];
    in_data_b  = PT1;
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    checks++; if (in_ready_b !== 1'b0) begin errors++; $display("FAIL aes256_busy_ready got %b want 0", in_ready_b); end
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid_b && n < 40);
    checks++; if (n != 14) begin errors++; $display("FAIL aes256_latency got %0d want 14", n); end
    checks++; if (out_data_b !== CT3) begin errors++; $display("FAIL aes256_data got %h want %h", out_data_b, CT3); end
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    checks++;
    if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
      errors++; $display("FAIL aes256_handshake got valid=%b ready=%b want 0/1", out_valid_b, in_ready_b);
    end
  endtask

  task automatic test_backpressure;
    int n;
    load_key_a(KEY1);
    in_data_a  = PT1;
    in_valid_a = 1'b1;
    tick();
    wait_out_a(n);
    checks++; if (n != 10) begin errors++; $display("FAIL bp_latency got %0d want 10", n); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== CT1 || in_ready_a !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b data=%h want 1/0/%h",
                 i, out_valid_a, in_ready_a, out_data_a, CT1);
      end
    end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid_a); end
`ifdef AES_ENC_B2B_EN
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL bp_b2b_accept got ready=%b want 0", in_ready_a); end
    in_valid_a = 1'b0;
`else
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got %b want 1", in_ready_a); end
    tick();
    in_valid_a = 1'b0;
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL bp_next_accept got ready=%b want 0", in_ready_a); end
`endif
    wait_out_a(n);
    checks++; if (n != 10) begin errors++; $display("FAIL bp_second_latency got %0d want 10", n); end
    checks++; if (out_data_a !== CT1) begin errors++; $display("FAIL bp_second_data got %h want %h", out_data_a, CT1); end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    int bad;
    load_key_a(KEY1);
    accept_a(PT1);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", in_ready_a); end
    checks++; if (out_data_a !== 128'h0) begin errors++; $display("FAIL midrst_data got %h want 0", out_data_a); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_aborted got %0d valid cycles want 0", bad); end
    accept_a(PT1);
    wait_out_a(n);
    checks++; if (n != 10) begin errors++; $display("FAIL midrst_rerun_latency got %0d want 10", n); end
    checks++; if (out_data_a !== CT1) begin errors++; $display("FAIL midrst_rerun_data got %h want %h", out_data_a, CT1); end
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    int gap;
    load_key_a(KEY1);
    in_data_a   = PT1;
    in_valid_a  = 1'b1;
    out_ready_a = 1'b1;
    tick();
    wait_out_a(n);
    checks++; if (n != 10) begin errors++; $display("FAIL b2b_first_latency got %0d want 10", n); end
    checks++; if (out_data_a !== CT1) begin errors++; $display("FAIL b2b_first_data got %h want %h", out_data_a, CT1); end
`ifdef AES_ENC_B2B_EN
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL b2b_done_ready got %b want 1", in_ready_a); end
    load_key_a(KEY2);
    in_data_a = PT2;
    tick();
    gap = 1;
    in_valid_a = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) begin
      errors++; $display("FAIL b2b_same_cycle_load got valid=%b ready=%b want 0/0", out_valid_a, in_ready_a);
    end
    while (!out_valid_a && gap < 40) begin
      tick();
      gap++;
    end
    checks++; if (gap != 11) begin errors++; $display("FAIL b2b_gap got %0d want 11", gap); end
    checks++; if (out_data_a !== CT2) begin errors++; $display("FAIL b2b_second_data got %h want %h", out_data_a, CT2); end
`else
    checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL seq_done_ready got %b want 0", in_ready_a); end
    tick();
    gap = 1;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++; $display("FAIL seq_idle_between got valid=%b ready=%b want 0/1", out_valid_a, in_ready_a);
    end
    tick();
    gap++;
    in_valid_a = 1'b0;
    while (!out_valid_a && gap < 40) begin
      tick();
      gap++;
    end
    checks++; if (gap != 12) begin errors++; $display("FAIL seq_gap got %0d want 12", gap); end
    checks++; if (out_data_a !== CT1) begin errors++; $display("FAIL seq_second_data got %h want %h", out_data_a, CT1); end
`endif
    tick();
    out_ready_a = 1'b0;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL b2b_final_handshake got %b want 0", out_valid_a); end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    in_data_a   = '0;
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    in_data_b   = '0;
    for (int j = 0; j < 44; j++) kexp_a[j] = '0;
    for (int j = 0; j < 60; j++) kexp_b[j] = '0;
    build_sbox();
    test_reset();
    test_aes128("vec1", KEY1, PT1, CT1);
    test_aes128("vec2", KEY2, PT2, CT2);
    test_aes256();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
